// File: rtl/im_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | im_pkg : shared types, defaults and address decode for im_fetch_port    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package im_pkg;

  localparam int IM_ARCH_WIDTH = 32;
  localparam int IM_WORD_WIDTH = 32;
  localparam int IM_DEPTH_DEF  = 10;

  localparam logic [IM_ARCH_WIDTH-1:0] IM_BASE_ADDR_DEF = 32'h0000_0000;
  // ori 0,0,0
  localparam logic [0:IM_WORD_WIDTH-1] IM_NOP_INSN      = 32'h6000_0000;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  typedef struct packed {
    logic                     in_range;
    logic [IM_ARCH_WIDTH-1:0] index;
  } im_range_t;

  function automatic im_range_t im_in_range(
    input logic [IM_ARCH_WIDTH-1:0] addr,
    input logic [IM_ARCH_WIDTH-1:0] base,
    input int unsigned              depth
  );
    im_range_t                rng;
    logic [IM_ARCH_WIDTH-1:0] off;
    off          = addr - base;
    rng.in_range = ((off >> (depth + 32'd2)) == '0);
    rng.index    = (off >> 2) & ~({IM_ARCH_WIDTH{1'b1}} << depth);
    return rng;
  endfunction

endpackage
`default_nettype wire

// File: rtl/im_fetch_port_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | im_fetch_port_if : fetch request/response and program-load bundle       |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface im_fetch_port_if
  import im_pkg::*;
#(
  parameter int ARCH_WIDTH = IM_ARCH_WIDTH,
  parameter int IM_WIDTH   = IM_WORD_WIDTH,
  parameter int IM_DEPTH   = IM_DEPTH_DEF
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ARCH_WIDTH-1:0] req_addr;
  logic                  flush;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [0:IM_WIDTH-1]   rsp_data;
  logic [ARCH_WIDTH-1:0] rsp_pc;
  logic                  rsp_fault;
  logic                  ld_en;
  logic [IM_DEPTH-1:0]   ld_addr;
  logic [0:IM_WIDTH-1]   ld_data;

  modport master (
    output req_valid, req_addr, flush, rsp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_pc, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_pc, rsp_fault
  );
endinterface
`default_nettype wire

// File: rtl/im_ram_sp.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | im_ram_sp : synchronous single-port RAM, write priority, 1-cycle read   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module im_ram_sp #(
  parameter int WIDTH = 32,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             re_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [0:WIDTH-1] wdata_i,
  output logic [0:WIDTH-1] rdata_o
);

`ifdef USE_RAMIP
  vendor_bram_sp #(
    .DATA_W (WIDTH),
    .ADDR_W (AW)
  ) u_bram (
    .clk  (clk),
    .en   (re_i | we_i),
    .we   (we_i),
    .addr (addr_i),
    .din  (wdata_i),
    .dout (rdata_o)
  );
`else
  logic [0:WIDTH-1] mem_q [2**AW];
  logic [0:WIDTH-1] rdata_q;

  // The read register only moves on a read, so it doubles as the hold stage.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
`endif

endmodule
`default_nettype wire

// File: rtl/im_fetch_port.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | im_fetch_port : IF-stage instruction memory with fetch handshake,       |
// |                 flush, fault flagging and program-load port             |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module im_fetch_port
  import im_pkg::*;
#(
  parameter int                    ARCH_WIDTH   = IM_ARCH_WIDTH,
  parameter int                    IM_WIDTH     = IM_WORD_WIDTH,
  parameter int                    IM_DEPTH     = IM_DEPTH_DEF,
  parameter logic [ARCH_WIDTH-1:0] IM_BASE_ADDR = IM_BASE_ADDR_DEF,
  parameter logic [0:IM_WIDTH-1]   FAULT_INSN   = IM_NOP_INSN
) (
  input  logic         clk,
  input  logic         rst_n,
  im_fetch_port_if.slave bus
);

  im_range_t             rng;
  logic                  req_fault;
  logic [IM_DEPTH-1:0]   req_index;
  logic                  req_ready;
  logic                  req_fire;
  logic                  rsp_valid;
  logic                  ram_re;
  logic [IM_DEPTH-1:0]   ram_addr;
  logic [0:IM_WIDTH-1]   ram_rdata;
  logic                  unused_idx;

  rsp_state_e            state_q;
  logic [ARCH_WIDTH-1:0] pc_q;
  logic                  fault_q;

  assign rng        = im_in_range(bus.req_addr, IM_BASE_ADDR, IM_DEPTH);
  assign req_index  = rng.index[IM_DEPTH-1:0];
  assign unused_idx = ^rng.index[IM_ARCH_WIDTH-1:IM_DEPTH];
  assign req_fault  = !rng.in_range || (bus.req_addr[1:0] != 2'b00);

  assign rsp_valid  = (state_q == RSP_FULL);
  assign req_ready  = !bus.ld_en && (!rsp_valid || bus.rsp_ready || bus.flush);
  assign req_fire   = bus.req_valid && req_ready;

  // Loads and fetches never overlap since a load drops req_ready.
  assign ram_re     = req_fire && !req_fault;
  assign ram_addr   = bus.ld_en ? bus.ld_addr : req_index;

  im_ram_sp #(
    .WIDTH (IM_WIDTH),
    .AW    (IM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .re_i    (ram_re),
    .we_i    (bus.ld_en),
    .addr_i  (ram_addr),
    .wdata_i (bus.ld_data),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RSP_EMPTY;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        RSP_EMPTY: if (req_fire) state_q <= RSP_FULL;
        RSP_FULL:  if (!req_fire && (bus.rsp_ready || bus.flush)) state_q <= RSP_EMPTY;
        default:   state_q <= RSP_EMPTY;
      endcase
      if (req_fire) begin
        pc_q    <= bus.req_addr;
        fault_q <= req_fault;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_pc    = pc_q;
  assign bus.rsp_fault = fault_q;
  // Gated by valid so the word reads zero out of reset without resetting the RAM.
  assign bus.rsp_data  = !rsp_valid ? '0 : (fault_q ? FAULT_INSN : ram_rdata);

endmodule
`default_nettype wire

// File: tb/tb_im_fetch_port.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_im_fetch_port : directed bench with a word-level reference model     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_im_fetch_port;

  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int          SIZE    = 1024;
  localparam logic [31:0] NOP     = 32'h6000_0000;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  bit   run_cmp;

  im_fetch_port_if #(.ARCH_WIDTH(32), .IM_WIDTH(32), .IM_DEPTH(10)) bus ();

  im_fetch_port dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: a fired fetch yields its whole answer one cycle later.
  logic [31:0] m_mem [0:SIZE-1];
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_data;
  logic        m_fault;
  logic        m_fire;
  logic [31:0] m_off;

  function automatic logic m_ready();
    return !bus.ld_en && (!m_valid || bus.rsp_ready || bus.flush);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_pc    = 32'h0;
      m_data  = 32'h0;
      m_fault = 1'b0;
    end else begin
      m_fire = bus.req_valid && m_ready();
      if (bus.ld_en) m_mem[int'(bus.ld_addr)] = bus.ld_data;
      if (m_fire) begin
        m_off   = bus.req_addr - BASE;
        m_fault = (m_off >= 32'(4 * SIZE)) || (bus.req_addr % 4 != 0);
        m_data  = m_fault ? NOP : m_mem[int'(m_off / 4)];
        m_pc    = bus.req_addr;
        m_valid = 1'b1;
      end else if (bus.rsp_ready || bus.flush) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("cmp req_ready", 32'(bus.req_ready), 32'(m_ready()));
      check("cmp rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
      if (m_valid) begin
        check("cmp rsp_data", bus.rsp_data, m_data);
        check("cmp rsp_pc", bus.rsp_pc, m_pc);
        check("cmp rsp_fault", 32'(bus.rsp_fault), 32'(m_fault));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] data);
    bus.ld_en   = 1'b1;
    bus.ld_addr = 10'(idx);
    bus.ld_data = data;
    step();
    bus.ld_en   = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input logic [31:0] data,
                            input logic [31:0] pc, input logic fault);
    check({name, " valid"}, 32'(bus.rsp_valid), 32'd1);
    check({name, " data"}, bus.rsp_data, data);
    check({name, " pc"}, bus.rsp_pc, pc);
    check({name, " fault"}, 32'(bus.rsp_fault), 32'(fault));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    run_cmp     = 1'b0;
    rst_n       = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.ld_en     = 1'b0;
    bus.ld_addr   = 10'h0;
    bus.ld_data   = 32'h0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_data", bus.rsp_data, 32'h0);
    check("reset rsp_pc", bus.rsp_pc, 32'h0);
    check("reset rsp_fault", 32'(bus.rsp_fault), 32'd0);
    rst_n   = 1'b1;
    run_cmp = 1'b1;
    step();

    // Program load then back-to-back fetches.
    for (int i = 0; i < 4; i++) load(i, 32'h3800_0001 + 32'(i));
    load(SIZE - 1, 32'hDEAD_BEEF);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr = 32'(4 * i);
      step();
      expect_rsp("b2b", 32'h3800_0001 + 32'(i), 32'(4 * i), 1'b0);
    end
    bus.req_valid = 1'b0;
    step();

    // Back-pressure holds the word.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h4;
    step();
    bus.req_addr  = 32'h8;
    for (int i = 0; i < 3; i++) begin
      check("stall req_ready", 32'(bus.req_ready), 32'd0);
      expect_rsp("stall", 32'h3800_0002, 32'h4, 1'b0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("release req_ready", 32'(bus.req_ready), 32'd1);
    step();
    expect_rsp("release", 32'h3800_0003, 32'h8, 1'b0);
    bus.req_valid = 1'b0;
    step();

    // Faults and the last in-range word.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h2;
    step();
    expect_rsp("misaligned", NOP, 32'h2, 1'b1);
    bus.req_addr  = BASE + 32'(4 * SIZE);
    step();
    expect_rsp("out of range", NOP, BASE + 32'(4 * SIZE), 1'b1);
    bus.req_addr  = BASE + 32'(4 * SIZE - 4);
    step();
    expect_rsp("last word", 32'hDEAD_BEEF, BASE + 32'(4 * SIZE - 4), 1'b0);
    bus.req_valid = 1'b0;
    step();

    // Flush with redirect in the same cycle.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h8;
    step();
    bus.flush    = 1'b1;
    bus.req_addr = 32'hC;
    #1;
    check("flush req_ready", 32'(bus.req_ready), 32'd1);
    step();
    expect_rsp("redirect", 32'h3800_0004, 32'hC, 1'b0);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();

    // Load blocks requests; an existing response survives a later load.
    bus.ld_en     = 1'b1;
    bus.ld_addr   = 10'd1;
    bus.ld_data   = 32'h7C08_02A6;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h4;
    #1;
    check("load req_ready", 32'(bus.req_ready), 32'd0);
    step();
    check("load no rsp", 32'(bus.rsp_valid), 32'd0);
    bus.ld_en = 1'b0;
    step();
    expect_rsp("reloaded", 32'h7C08_02A6, 32'h4, 1'b0);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    load(2, 32'h1111_1111);
    expect_rsp("load keeps rsp", 32'h7C08_02A6, 32'h4, 1'b0);

    // Asynchronous reset mid-response; memory survives.
    #1 rst_n = 1'b0;
    #1;
    check("async rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("async rsp_data", bus.rsp_data, 32'h0);
    check("async rsp_pc", bus.rsp_pc, 32'h0);
    check("async rsp_fault", 32'(bus.rsp_fault), 32'd0);
    step();
    rst_n         = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    step();
    expect_rsp("after reset", 32'h3800_0001, 32'h0, 1'b0);
    bus.req_valid = 1'b0;
    step();
    step();
    run_cmp = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
